csi_rx_packet_handler: RTL and testbench
========================================

// Module: csi_rx_packet_handler
// PURPOSE
//  Consumes lane-deskewed words and their valid flag from the word aligner, parses the CSI-2 packet header,
//  strips long-packet payload, and emits frame/line markers. Generates 'packet_done' (to the word aligner,
//  which forwards it to the byte aligners) and 'sync_wait' (the aligners' wait_for_sync). Sits between word aligner and ISP.
// PARAMETERS
//  NUM_LANE  2      lanes per word; legal 1,2,4; bytes per word = NUM_LANE
//  MAX_WC    16'd8192  largest accepted long-packet word count (bytes); larger -> length error
// PORTS
//  byte_clock     in   1            byte clock; all logic on rising edge
//  reset          in   1            asynchronous, active-high reset
//  enable         in   1            active-1; when 0 all state/outputs hold
//  data           in   NUM_LANE*8   aligned word; lane i = byte i of stream (lane0 = earliest byte)
//  data_valid     in   1            word valid; first valid word carries header byte DI on lane0
//  sync_wait      out  1            1 = idle, aligners may search/lock SYNC
//  packet_done    out  1            1-cycle pulse: packet ended (normal or abort)
//  payload        out  NUM_LANE*8   long-packet payload word (includes CRC bytes in last word if WC%NUM_LANE!=0)
//  payload_valid  out  1            payload qualifier
//  data_type      out  6            DT of current packet, held until next header
//  word_count     out  16           WC of current packet, held until next header
//  frame_start    out  1            1-cycle pulse on DT=0x00 header;  frame_end: pulse on DT=0x01
//  frame_end      out  1            see above
//  line_start     out  1            1-cycle pulse on long-packet header (DT>=0x10)
//  in_frame       out  1            set by frame_start, cleared by frame_end
//  err_len        out  1            1-cycle pulse: WC>MAX_WC
//  err_trunc      out  1            1-cycle pulse: data_valid dropped inside packet
// BEHAVIOUR
//  Reset (async assert, sync deassert use): state=IDLE, sync_wait=1, all other outputs 0.
//  HDR_WORDS=4/NUM_LANE. Header bytes in order DI,WC_L,WC_H,ECC; DT=DI[5:0]; ECC not checked.
//  Derived: PW=ceil(WC/NUM_LANE) payload words; TW=ceil((WC+2)/NUM_LANE) body words (payload+CRC).
//  States:
//   IDLE:  sync_wait=1. data_valid=1 -> capture bytes, HEADER (HDR_WORDS=1: decode same cycle).
//   HEADER: collect remaining header words; on last header word decode:
//     DT<0x10 (short) -> DONE; markers pulse next cycle.
//     long & WC>MAX_WC -> err_len, DONE (no payload).
//     long -> line_start, BODY with word counter=0 (WC=0: TW=1 CRC word only).
//   BODY: each valid word increments counter; payload_valid=1 while counter<PW; last word (counter=TW-1) -> DONE.
//   DONE: packet_done=1 for exactly one cycle -> HOLDOFF.
//   HOLDOFF: ignore data; wait for data_valid=0 (aligner valid is registered, may stay high 1-3 cycles), then IDLE.
//  data_valid=0 in HEADER or BODY -> err_trunc pulse, DONE; payload_valid deasserts same cycle.
//  Latency: payload/payload_valid registered, 1 cycle after the input word. packet_done 1 cycle after last input word.
//  sync_wait=0 in all states except IDLE.
//  Markers/err pulses are registered and asserted 1 cycle after the decoding word; simultaneous err_trunc and frame markers never occur.
//  frame_start while in_frame=1: pulse again, in_frame stays 1. frame_end while in_frame=0: pulse, no change.
//  enable=0: counters, state, and pulse outputs frozen; pulses resume with enable.
//  Counters 16-bit, no wrap (TW<=ceil((MAX_WC+2)/NUM_LANE)).
// TESTING (NUM_LANE=2)
//  Short FS: words 0x0100,0xA500 -> frame_start, in_frame=1, packet_done 1 cycle after word2, no payload_valid.
//  Long DT=0x2B, WC=10: header 0x0A2B,0xXX00 + 6 body words -> line_start, 5 payload_valid cycles, packet_done after 6th.
//  Odd WC=7: PW=4, TW=5 -> 4 payload words, packet_done after body word 5; sync_wait back to 1 after data_valid low.
//  Truncation: WC=10, data_valid drops after 2 body words -> err_trunc, packet_done pulses, payload_valid count=2.
//  WC=0x4000 (>MAX_WC) -> err_len, packet_done, zero payload_valid, HOLDOFF until data_valid=0.
//  Async reset mid-BODY -> all outputs 0 and sync_wait=1 immediately, no clock edge required; next header parses normally.

Source files
------------

// File: rtl/csi_rx_packet_handler.sv
// CSI-2 packet handler: parses the packet header, strips long-packet payload,
// emits frame/line markers and the packet_done / sync_wait handshake to the aligners.
module csi_rx_packet_handler #(
    parameter int          NUM_LANE = 2,
    parameter logic [15:0] MAX_WC   = 16'd8192
) (
    input  logic                    byte_clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_LANE*8-1:0]   data,
    input  logic                    data_valid,
    output logic                    sync_wait,
    output logic                    packet_done,
    output logic [NUM_LANE*8-1:0]   payload,
    output logic                    payload_valid,
    output logic [5:0]              data_type,
    output logic [15:0]             word_count,
    output logic                    frame_start,
    output logic                    frame_end,
    output logic                    line_start,
    output logic                    in_frame,
    output logic                    err_len,
    output logic                    err_trunc
);

    localparam int         W         = NUM_LANE * 8;
    localparam int         HDR_WORDS = 4 / NUM_LANE;
    localparam int         LOG2      = (NUM_LANE == 4) ? 2 : ((NUM_LANE == 2) ? 1 : 0);
    localparam logic [1:0] HDR_LAST  = 2'(HDR_WORDS - 1);
    localparam logic [16:0] RND      = 17'(NUM_LANE - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        BODY,
        DONE,
        HOLDOFF
    } state_t;

    state_t      state;
    logic [31:0] hdr;
    logic [31:0] hdr_cur;
    logic [1:0]  hidx;
    logic [15:0] cnt;
    logic [15:0] pw;
    logic [15:0] tw_last;

    logic [5:0]  dt_cur;
    logic [15:0] wc_cur;
    logic [16:0] pw_calc;
    logic [16:0] tw_calc;
    logic [16:0] tw_last_calc;
    logic        is_long;
    logic        too_long;

    // Header bytes accumulate across words; the incoming word is merged in
    // so the final header word can be decoded in the cycle it arrives.
    always_comb begin
        hdr_cur = hdr;
        for (int k = 0; k < HDR_WORDS; k++) begin
            if (hidx == 2'(k)) begin
                hdr_cur[k*W +: W] = data;
            end
        end
        dt_cur       = hdr_cur[5:0];
        wc_cur       = hdr_cur[23:8];
        pw_calc      = ({1'b0, wc_cur} + RND) >> LOG2;
        tw_calc      = ({1'b0, wc_cur} + 17'd2 + RND) >> LOG2;
        tw_last_calc = tw_calc - 17'd1;
        is_long      = (dt_cur >= 6'h10);
        too_long     = (wc_cur > MAX_WC);
    end

    logic unused_ok;
    assign unused_ok = ^{hdr_cur[31:24], hdr_cur[7:6], pw_calc[16], tw_last_calc[16]};

    always_ff @(posedge byte_clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hdr           <= '0;
            hidx          <= '0;
            cnt           <= '0;
            pw            <= '0;
            tw_last       <= '0;
            sync_wait     <= 1'b1;
            packet_done   <= 1'b0;
            payload       <= '0;
            payload_valid <= 1'b0;
            data_type     <= '0;
            word_count    <= '0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            in_frame      <= 1'b0;
            err_len       <= 1'b0;
            err_trunc     <= 1'b0;
        end else if (enable) begin
            packet_done   <= 1'b0;
            payload_valid <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            err_len       <= 1'b0;
            err_trunc     <= 1'b0;
            unique case (state)
                IDLE, HEADER: begin
                    if (data_valid) begin
                        hdr       <= hdr_cur;
                        sync_wait <= 1'b0;
                        if (hidx == HDR_LAST) begin
                            hidx       <= '0;
                            data_type  <= dt_cur;
                            word_count <= wc_cur;
                            cnt        <= '0;
                            pw         <= pw_calc[15:0];
                            tw_last    <= tw_last_calc[15:0];
                            if (!is_long) begin
                                state       <= DONE;
                                packet_done <= 1'b1;
                                frame_start <= (dt_cur == 6'h00);
                                frame_end   <= (dt_cur == 6'h01);
                                if (dt_cur == 6'h00) begin
                                    in_frame <= 1'b1;
                                end else if (dt_cur == 6'h01) begin
                                    in_frame <= 1'b0;
                                end
                            end else if (too_long) begin
                                state       <= DONE;
                                packet_done <= 1'b1;
                                err_len     <= 1'b1;
                            end else begin
                                state      <= BODY;
                                line_start <= 1'b1;
                            end
                        end else begin
                            hidx  <= hidx + 2'd1;
                            state <= HEADER;
                        end
                    end else if (state == HEADER) begin
                        hidx        <= '0;
                        state       <= DONE;
                        packet_done <= 1'b1;
                        err_trunc   <= 1'b1;
                    end
                end
                BODY: begin
                    if (data_valid) begin
                        payload       <= data;
                        payload_valid <= (cnt < pw);
                        cnt           <= cnt + 16'd1;
                        if (cnt == tw_last) begin
                            state       <= DONE;
                            packet_done <= 1'b1;
                        end
                    end else begin
                        state       <= DONE;
                        packet_done <= 1'b1;
                        err_trunc   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= HOLDOFF;
                end
                // aligner valid is registered and can linger a few cycles
                HOLDOFF: begin
                    if (!data_valid) begin
                        state     <= IDLE;
                        sync_wait <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sync_wait <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// Randomized bench for csi_rx_packet_handler (NUM_LANE=2) with a packet-level
// reference model: expected markers, payload words and latencies per packet.
module tb_csi_rx_packet_handler;

    logic        byte_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] data;
    logic        data_valid;
    logic        sync_wait;
    logic        packet_done;
    logic [15:0] payload;
    logic        payload_valid;
    logic [5:0]  data_type;
    logic [15:0] word_count;
    logic        frame_start;
    logic        frame_end;
    logic        line_start;
    logic        in_frame;
    logic        err_len;
    logic        err_trunc;

    int checks = 0;
    int errors = 0;

    always #5 byte_clock = ~byte_clock;

    csi_rx_packet_handler #(.NUM_LANE(2), .MAX_WC(16'd8192)) dut (
        .byte_clock    (byte_clock),
        .reset         (reset),
        .enable        (enable),
        .data          (data),
        .data_valid    (data_valid),
        .sync_wait     (sync_wait),
        .packet_done   (packet_done),
        .payload       (payload),
        .payload_valid (payload_valid),
        .data_type     (data_type),
        .word_count    (word_count),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .line_start    (line_start),
        .in_frame      (in_frame),
        .err_len       (err_len),
        .err_trunc     (err_trunc)
    );

    int   cyc  = 0;
    logic en_s = 1'b0;
    always @(posedge byte_clock) begin
        cyc  <= cyc + 1;
        en_s <= enable;
    end

    // Event log: every output value produced by an enabled edge is counted once.
    int n_done = 0, n_fs = 0, n_fe = 0, n_ls = 0, n_el = 0, n_et = 0, n_pl = 0;
    int done_cyc = -1;
    logic [15:0] pl_log [0:16383];
    always @(negedge byte_clock) begin
        if (!reset && en_s) begin
            if (packet_done) begin n_done++; done_cyc = cyc; end
            if (frame_start) n_fs++;
            if (frame_end)   n_fe++;
            if (line_start)  n_ls++;
            if (err_len)     n_el++;
            if (err_trunc)   n_et++;
            if (payload_valid && n_pl < 16384) begin
                pl_log[n_pl] = payload;
                n_pl++;
            end
        end
    end

    logic        rand_en = 1'b0;
    logic        exp_in_frame = 1'b0;
    logic [5:0]  exp_dt = '0;
    logic [15:0] exp_wc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One word is consumed at the first edge where enable is high.
    task automatic step(input logic v, input logic [15:0] w);
        int tries = 0;
        data       = w;
        data_valid = v;
        do begin
            enable = (rand_en && tries < 50) ? ($urandom_range(0, 3) != 0) : 1'b1;
            tries++;
            @(posedge byte_clock);
            #1;
        end while (!en_s);
        enable = 1'b1;
    endtask

    task automatic run_packet(input logic [5:0] dt, input logic [15:0] wc,
                              input int trunc_at, input bit hdr_cut);
        int s_done, s_fs, s_fe, s_ls, s_el, s_et, s_pl;
        int tw, pw, nsend, npl, last_cyc;
        logic long_p, bad;
        logic [15:0] w;
        logic [15:0] body [$];
        s_done = n_done; s_fs = n_fs; s_fe = n_fe; s_ls = n_ls;
        s_el = n_el; s_et = n_et; s_pl = n_pl;
        long_p = (dt >= 6'h10);
        bad    = long_p && (wc > 16'd8192);
        npl    = 0;
        step(1'b1, {wc[7:0], 2'($urandom), dt});
        chk("sync_busy", 32'(sync_wait), 0);
        if (hdr_cut) begin
            step(1'b0, 16'($urandom));
        end else begin
            step(1'b1, {8'($urandom), wc[15:8]});
            if (long_p && !bad) begin
                tw    = (int'(wc) + 3) / 2;
                pw    = (int'(wc) + 1) / 2;
                nsend = (trunc_at < 0) ? tw : trunc_at;
                for (int i = 0; i < nsend; i++) begin
                    w = 16'($urandom);
                    body.push_back(w);
                    step(1'b1, w);
                end
                if (trunc_at >= 0) step(1'b0, 16'($urandom));
                npl = (nsend < pw) ? nsend : pw;
            end
        end
        last_cyc = cyc;
        repeat ($urandom_range(0, 3)) step(1'b1, 16'($urandom));
        repeat (3) step(1'b0, 16'h0000);
        if (!hdr_cut) begin
            if (!long_p && dt == 6'h00) exp_in_frame = 1'b1;
            if (!long_p && dt == 6'h01) exp_in_frame = 1'b0;
            exp_dt = dt;
            exp_wc = wc;
        end
        chk("done_cnt", 32'(n_done - s_done), 1);
        chk("done_lat", 32'(done_cyc), 32'(last_cyc));
        chk("fs_cnt", 32'(n_fs - s_fs), (!hdr_cut && dt == 6'h00) ? 1 : 0);
        chk("fe_cnt", 32'(n_fe - s_fe), (!hdr_cut && dt == 6'h01) ? 1 : 0);
        chk("ls_cnt", 32'(n_ls - s_ls), (!hdr_cut && long_p && !bad) ? 1 : 0);
        chk("el_cnt", 32'(n_el - s_el), (!hdr_cut && bad) ? 1 : 0);
        chk("et_cnt", 32'(n_et - s_et),
            (hdr_cut || (long_p && !bad && trunc_at >= 0)) ? 1 : 0);
        chk("pl_cnt", 32'(n_pl - s_pl), 32'(npl));
        for (int i = 0; i < npl && (s_pl + i) < n_pl; i++) begin
            chk("pl_data", 32'(pl_log[s_pl + i]), 32'(body[i]));
        end
        chk("in_frame", 32'(in_frame), 32'(exp_in_frame));
        chk("data_type", 32'(data_type), 32'(exp_dt));
        chk("word_count", 32'(word_count), 32'(exp_wc));
        chk("sync_idle", 32'(sync_wait), 1);
    endtask

    initial begin
        int s_ls, s_pl, s_done;
        logic [5:0]  dt;
        logic [15:0] wc;
        int tr, r;

        reset = 1'b1; enable = 1'b0; data = '0; data_valid = 1'b0;
        repeat (3) @(posedge byte_clock);
        #1;
        chk("rst_sync", 32'(sync_wait), 1);
        chk("rst_done", 32'(packet_done), 0);
        chk("rst_pv", 32'(payload_valid), 0);
        chk("rst_inframe", 32'(in_frame), 0);
        chk("rst_dt", 32'(data_type), 0);
        chk("rst_wc", 32'(word_count), 0);
        reset = 1'b0; enable = 1'b1;
        repeat (2) @(posedge byte_clock);
        #1;

        run_packet(6'h00, 16'h0001, -1, 1'b0);
        run_packet(6'h2B, 16'd10, -1, 1'b0);
        run_packet(6'h2B, 16'd7, -1, 1'b0);
        run_packet(6'h2B, 16'd10, 2, 1'b0);
        run_packet(6'h2B, 16'h4000, -1, 1'b0);
        run_packet(6'h12, 16'd0, -1, 1'b0);
        run_packet(6'h01, 16'h0002, -1, 1'b0);
        run_packet(6'h01, 16'h0003, -1, 1'b0);
        run_packet(6'h00, 16'h0004, -1, 1'b0);
        run_packet(6'h00, 16'h0005, -1, 1'b0);
        run_packet(6'h2A, 16'd6, -1, 1'b1);
        run_packet(6'h1E, 16'd8192, -1, 1'b0);
        run_packet(6'h1E, 16'd8193, -1, 1'b0);
        run_packet(6'h2C, 16'd9, 0, 1'b0);

        // Freeze with enable low right after a long header decode.
        s_ls = n_ls; s_pl = n_pl; s_done = n_done;
        step(1'b1, 16'h042C);
        step(1'b1, 16'h3300);
        chk("frz_ls_pre", 32'(line_start), 1);
        enable = 1'b0;
        repeat (3) @(posedge byte_clock);
        #1;
        chk("frz_ls_hold", 32'(line_start), 1);
        chk("frz_sync", 32'(sync_wait), 0);
        chk("frz_done", 32'(packet_done), 0);
        step(1'b1, 16'h1111);
        step(1'b1, 16'h2222);
        step(1'b1, 16'h3333);
        repeat (3) step(1'b0, 16'h0000);
        exp_dt = 6'h2C; exp_wc = 16'd4;
        chk("frz_ls_cnt", 32'(n_ls - s_ls), 1);
        chk("frz_pl_cnt", 32'(n_pl - s_pl), 2);
        chk("frz_done_cnt", 32'(n_done - s_done), 1);
        chk("frz_pl0", 32'(pl_log[s_pl]), 32'h1111);
        chk("frz_pl1", 32'(pl_log[s_pl + 1]), 32'h2222);

        // Asynchronous reset in the middle of a body.
        step(1'b1, 16'h1428);
        step(1'b1, 16'h5500);
        step(1'b1, 16'hAAAA);
        step(1'b1, 16'hBBBB);
        chk("ar_pv_pre", 32'(payload_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_pv", 32'(payload_valid), 0);
        chk("ar_sync", 32'(sync_wait), 1);
        chk("ar_dt", 32'(data_type), 0);
        chk("ar_wc", 32'(word_count), 0);
        chk("ar_inframe", 32'(in_frame), 0);
        data_valid = 1'b0;
        @(posedge byte_clock);
        #1;
        reset = 1'b0;
        exp_in_frame = 1'b0; exp_dt = '0; exp_wc = '0;
        run_packet(6'h2A, 16'd6, -1, 1'b0);

        rand_en = 1'b1;
        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      dt = 6'h00;
            else if (r == 1) dt = 6'h01;
            else if (r == 2) dt = 6'($urandom_range(2, 15));
            else             dt = 6'($urandom_range(16, 63));
            if (dt < 6'h10)                  wc = 16'($urandom);
            else if ($urandom_range(0, 9) == 0) wc = 16'($urandom_range(8193, 65535));
            else                             wc = 16'($urandom_range(0, 24));
            tr = -1;
            if (dt >= 6'h10 && wc <= 16'd8192 && $urandom_range(0, 3) == 0)
                tr = $urandom_range(0, (int'(wc) + 3) / 2 - 1);
            run_packet(dt, wc, tr, ($urandom_range(0, 14) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
